// File: rtl/conv_result_checker.sv
// rtl/conv_result_checker.sv - snoops the conv accelerator output writes and checks them against a golden SRAM (optional CHK_MISMATCH_LOG_EN)
module conv_result_checker #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_RESULTS = 32,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] GOLDEN_BASE = '0,
  parameter int                    CYCLE_WIDTH = 32,
  parameter int                    ROUND_WIDTH = 8,
  localparam int                   CNT_W       = $clog2(NUM_RESULTS + 1)
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   dut_run,
  input  logic                   dut_busy,
  input  logic                   dut_sram_write_enable,
  input  logic [ADDR_WIDTH-1:0]  dut_sram_write_address,
  input  logic [DATA_WIDTH-1:0]  dut_sram_write_data,
  output logic [ADDR_WIDTH-1:0]  chk_golden_read_address,
  input  logic [DATA_WIDTH-1:0]  golden_chk_read_data,
  output logic                   chk_done,
  output logic                   chk_pass,
  output logic [CNT_W-1:0]       chk_correct_count,
  output logic [CYCLE_WIDTH-1:0] chk_cycle_count,
  output logic [7:0]             chk_stray_writes,
  output logic [ROUND_WIDTH-1:0] chk_round,
  output logic [ADDR_WIDTH-1:0]  chk_first_mismatch_address,
  output logic [DATA_WIDTH-1:0]  chk_first_mismatch_data
);

  localparam int IDX_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, OUT_BASE};
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH + 1)'(NUM_RESULTS);

  typedef enum logic [2:0] {IDLE, ARMED, BUSY, DRAIN, DONE} state_t;

  state_t                 state, state_next;
  logic                   start;
  logic                   active;
  logic                   in_window;
  logic                   in_range;
  logic                   stray_hit;
  logic                   count_en;
  logic [ADDR_WIDTH-1:0]  idx_full;
  logic [IDX_W-1:0]       idx;
  logic [ADDR_WIDTH-1:0]  golden_now;
  logic [ADDR_WIDTH-1:0]  golden_hold;

  logic                   s1_valid;
  logic [IDX_W-1:0]       s1_idx;
  logic [DATA_WIDTH-1:0]  s1_data;
  logic                   cmp_match;
  logic [NUM_RESULTS-1:0] match_vec;
  logic [NUM_RESULTS-1:0] written_vec;
  logic [NUM_RESULTS-1:0] written_next;
  logic [CNT_W-1:0]       correct_next;

  // Round sequencing: a run request in IDLE or DONE (re)starts a round
  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (dut_run) begin
          start      = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED:   if (dut_busy) state_next = BUSY;
      BUSY:    if (!dut_busy) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE: begin
        if (dut_run) begin
          start      = 1'b1;
          state_next = ARMED;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-port decode, golden address lookup and second-stage compare
  always_comb begin
    active     = (state != IDLE);
    in_window  = ({1'b0, dut_sram_write_address} >= WIN_LO) &&
                 ({1'b0, dut_sram_write_address} <  WIN_HI);
    in_range   = active && dut_sram_write_enable && in_window;
    stray_hit  = active && dut_sram_write_enable && !in_window;
    idx_full   = dut_sram_write_address - OUT_BASE;
    idx        = idx_full[IDX_W-1:0];
    golden_now = GOLDEN_BASE + idx_full;
    chk_golden_read_address = in_range ? golden_now : golden_hold;
    // The cycle that sees busy drop is not counted, so the count spans run sample to last busy cycle
    count_en   = (state == ARMED) || ((state == BUSY) && dut_busy);

    cmp_match    = (s1_data == golden_chk_read_data);
    correct_next = chk_correct_count;
    written_next = written_vec;
    if (s1_valid) begin
      written_next[s1_idx] = 1'b1;
      if (cmp_match && !match_vec[s1_idx]) begin
        correct_next = chk_correct_count + 1'b1;
      end else if (!cmp_match && match_vec[s1_idx]) begin
        correct_next = chk_correct_count - 1'b1;
      end
    end
  end

  // Round state, compare pipeline, counters and round result registers
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state             <= IDLE;
      golden_hold       <= '0;
      s1_valid          <= 1'b0;
      s1_idx            <= '0;
      s1_data           <= '0;
      match_vec         <= '0;
      written_vec       <= '0;
      chk_done          <= 1'b0;
      chk_pass          <= 1'b0;
      chk_correct_count <= '0;
      chk_cycle_count   <= '0;
      chk_stray_writes  <= '0;
      chk_round         <= '0;
    end else begin
      state <= state_next;
      if (in_range) begin
        golden_hold <= golden_now;
      end
      if (start) begin
        s1_valid          <= 1'b0;
        match_vec         <= '0;
        written_vec       <= '0;
        chk_done          <= 1'b0;
        chk_pass          <= 1'b0;
        chk_correct_count <= '0;
        chk_cycle_count   <= CYCLE_WIDTH'(1);
        chk_stray_writes  <= '0;
      end else begin
        if (count_en && (chk_cycle_count != '1)) begin
          chk_cycle_count <= chk_cycle_count + 1'b1;
        end
        s1_valid <= in_range;
        if (in_range) begin
          s1_idx  <= idx;
          s1_data <= dut_sram_write_data;
        end
        if (s1_valid) begin
          match_vec[s1_idx] <= cmp_match;
        end
        written_vec       <= written_next;
        chk_correct_count <= correct_next;
        if (stray_hit && (chk_stray_writes != 8'hFF)) begin
          chk_stray_writes <= chk_stray_writes + 8'd1;
        end
        // Entering DONE: the compare pipeline drains on this same edge, so use next-state values
        if (state == DRAIN) begin
          chk_done  <= 1'b1;
          chk_round <= chk_round + 1'b1;
          chk_pass  <= (correct_next == CNT_W'(NUM_RESULTS)) && (&written_next);
        end
      end
    end
  end

`ifdef CHK_MISMATCH_LOG_EN
  logic                  s1_valid_addr_unused;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  mm_logged;

  assign s1_valid_addr_unused = 1'b0;

  // First failing compare of a round captures its output address and DUT data
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      s1_addr                    <= '0;
      mm_logged                  <= 1'b0;
      chk_first_mismatch_address <= '0;
      chk_first_mismatch_data    <= '0;
    end else if (start) begin
      mm_logged                  <= 1'b0;
      chk_first_mismatch_address <= '0;
      chk_first_mismatch_data    <= '0;
    end else begin
      if (in_range) begin
        s1_addr <= dut_sram_write_address;
      end
      if (s1_valid && !cmp_match && !mm_logged) begin
        mm_logged                  <= 1'b1;
        chk_first_mismatch_address <= s1_addr;
        chk_first_mismatch_data    <= s1_data;
      end
    end
  end
`else
  assign chk_first_mismatch_address = '0;
  assign chk_first_mismatch_data    = '0;
`endif

endmodule

// File: tb/tb_conv_result_checker.sv
// tb/tb_conv_result_checker.sv - table-driven, scoreboarded bench for conv_result_checker
module tb_conv_result_checker;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int NR = 32;
  localparam int CW = 32;
  localparam int RW = 8;
  localparam int CNTW = $clog2(NR + 1);
  localparam logic [AW-1:0] OB = 12'h000;
  localparam logic [AW-1:0] GB = 12'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_b;
  logic            dut_run;
  logic            dut_busy;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   golden_rd;
  logic            chk_done;
  logic            chk_pass;
  logic [CNTW-1:0] chk_correct_count;
  logic [CW-1:0]   chk_cycle_count;
  logic [7:0]      chk_stray_writes;
  logic [RW-1:0]   chk_round;
  logic [AW-1:0]   mm_addr;
  logic [DW-1:0]   mm_data;

  conv_result_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RESULTS(NR),
    .OUT_BASE(OB), .GOLDEN_BASE(GB), .CYCLE_WIDTH(CW), .ROUND_WIDTH(RW)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .dut_run(dut_run),
    .dut_busy(dut_busy),
    .dut_sram_write_enable(we),
    .dut_sram_write_address(waddr),
    .dut_sram_write_data(wdata),
    .chk_golden_read_address(gaddr),
    .golden_chk_read_data(golden_rd),
    .chk_done(chk_done),
    .chk_pass(chk_pass),
    .chk_correct_count(chk_correct_count),
    .chk_cycle_count(chk_cycle_count),
    .chk_stray_writes(chk_stray_writes),
    .chk_round(chk_round),
    .chk_first_mismatch_address(mm_addr),
    .chk_first_mismatch_data(mm_data)
  );

  logic [DW-1:0] gold_mem [0:(1<<AW)-1];

  always @(posedge clk) golden_rd <= gold_mem[gaddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] gold(input int i);
    return gold_mem[GB + AW'(i)];
  endfunction

  typedef struct {
    int n_writes;
    int bad_idx;
    bit fix;
    int strays;
    int busy_len;
    int exp_correct;
    bit exp_pass;
    int exp_stray;
    int exp_cycle;
    int exp_round;
  } vec_t;

  typedef struct {
    int correct;
    bit pass;
    int stray;
    int cycle;
    int round;
    int mm_addr;
    int mm_data;
  } exp_t;

  exp_t sb[$];

  task automatic do_round(input vec_t v);
    exp_t e;
    logic [AW-1:0] oa[$];
    logic [DW-1:0] od[$];
    logic [DW-1:0] g;
    bit seen;
    e.correct = v.exp_correct;
    e.pass    = v.exp_pass;
    e.stray   = v.exp_stray;
    e.cycle   = v.exp_cycle;
    e.round   = v.exp_round;
    e.mm_addr = 0;
    e.mm_data = 0;
`ifdef CHK_MISMATCH_LOG_EN
    if (v.bad_idx >= 0) begin
      g = ~gold(v.bad_idx);
      e.mm_addr = int'(OB) + v.bad_idx;
      e.mm_data = int'(g);
    end
`endif
    sb.push_back(e);
    for (int i = 0; i < v.n_writes; i++) begin
      g = gold(i);
      oa.push_back(OB + AW'(i));
      od.push_back((i == v.bad_idx) ? ~g : g);
      if (i == v.bad_idx && v.fix) begin
        oa.push_back(OB + AW'(i));
        od.push_back(g);
      end
    end
    for (int s = 0; s < v.strays; s++) begin
      oa.push_back(12'h040);
      od.push_back(16'hDEAD);
    end

    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run  = 1'b0;
    dut_busy = 1'b1;
    check("start_clears_done", {63'd0, chk_done}, 64'd0);
    check("start_clears_correct", 64'(chk_correct_count), 64'd0);
    check("start_clears_stray", 64'(chk_stray_writes), 64'd0);
    for (int c = 0; c < v.busy_len; c++) begin
      if (c < oa.size()) begin
        we    = 1'b1;
        waddr = oa[c];
        wdata = od[c];
      end else begin
        we = 1'b0;
      end
      if (c == 0) begin
        #1;
        check("golden_addr_comb", 64'(gaddr), 64'(GB + (oa[0] - OB)));
      end
      @(negedge clk);
    end
    we       = 1'b0;
    dut_busy = 1'b0;

    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (chk_done) seen = 1'b1;
    end
    check("done_within_bound", {63'd0, seen}, 64'd1);
    e = sb.pop_front();
    check("correct_count", 64'(chk_correct_count), 64'(e.correct));
    check("pass", {63'd0, chk_pass}, {63'd0, e.pass});
    check("stray_writes", 64'(chk_stray_writes), 64'(e.stray));
    check("cycle_count", 64'(chk_cycle_count), 64'(e.cycle));
    check("round", 64'(chk_round), 64'(e.round));
    check("first_mm_addr", 64'(mm_addr), 64'(e.mm_addr));
    check("first_mm_data", 64'(mm_data), 64'(e.mm_data));
    @(negedge clk);
  endtask

  vec_t vecs[5];

  initial begin
    for (int a = 0; a < (1 << AW); a++) gold_mem[a] = DW'(a * 59) ^ 16'h5A5A;

    //          n   bad fix str busy  corr pass str cyc rnd
    vecs[0] = '{32, -1, 0,  0,  99,  32,  1,   0, 100, 1};
    vecs[1] = '{32,  5, 1,  0,  60,  32,  1,   0,  61, 2};
    vecs[2] = '{31, -1, 0,  0,  40,  31,  0,   0,  41, 3};
    vecs[3] = '{32, -1, 0,  3,  50,  32,  1,   3,  51, 4};
    vecs[4] = '{32,  7, 0,  0,  45,  31,  0,   0,  46, 5};

    reset_b  = 1'b0;
    dut_run  = 1'b1;
    dut_busy = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {63'd0, chk_done}, 64'd0);
    check("rst_pass", {63'd0, chk_pass}, 64'd0);
    check("rst_correct", 64'(chk_correct_count), 64'd0);
    check("rst_cycle", 64'(chk_cycle_count), 64'd0);
    check("rst_stray", 64'(chk_stray_writes), 64'd0);
    check("rst_round", 64'(chk_round), 64'd0);
    check("rst_gaddr", 64'(gaddr), 64'd0);
    check("rst_mm_addr", 64'(mm_addr), 64'd0);
    @(negedge clk);
    reset_b = 1'b1;
    dut_run = 1'b0;

    // A write while idle must not be compared or counted as stray
    we    = 1'b1;
    waddr = 12'h040;
    wdata = 16'h1234;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    check("idle_write_ignored", 64'(chk_stray_writes), 64'd0);
    check("idle_no_round", 64'(chk_round), 64'd0);

    for (int r = 0; r < 5; r++) do_round(vecs[r]);

    // Reset during the busy phase of a further round aborts it without counting
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run  = 1'b0;
    dut_busy = 1'b1;
    repeat (5) @(negedge clk);
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    check("abort_round", 64'(chk_round), 64'd0);
    check("abort_done", {63'd0, chk_done}, 64'd0);
    check("abort_cycle", 64'(chk_cycle_count), 64'd0);
    @(negedge clk);
    reset_b  = 1'b1;
    dut_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_stays_idle_done", {63'd0, chk_done}, 64'd0);
    check("abort_stays_round", 64'(chk_round), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_result_checker.md
Name: conv_result_checker

Overview:
- Synthesizable self-check block for the binary-convolution accelerator; sits beside MyDesign and snoops its output-SRAM write port and its dut_run/dut_busy handshake.
- Per round: measures compute cycles, compares every in-range output write against a golden SRAM, and keeps a last-write-wins correct-result count.
- Generalises the bench timer/comparator: parametrised width, depth, base addresses and round count, with out-of-range write detection.

Parameters:
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 16, SRAM data width
- NUM_RESULTS, 32, results checked per round (1..256)
- OUT_BASE, 12'h000, first checked output address
- GOLDEN_BASE, 12'h000, golden SRAM address of result 0
- CYCLE_WIDTH, 32, cycle counter width
- ROUND_WIDTH, 8, round counter width

Ports:
- clk  in  1  clock
- reset_b  in  1  synchronous active-low reset
- dut_run  in  1  snooped run request
- dut_busy  in  1  snooped busy
- dut_sram_write_enable  in  1  snooped output write enable
- dut_sram_write_address  in  ADDR_WIDTH  snooped write address
- dut_sram_write_data  in  DATA_WIDTH  snooped write data
- chk_golden_read_address  out  ADDR_WIDTH  golden SRAM read address
- golden_chk_read_data  in  DATA_WIDTH  golden data, valid one cycle after address
- chk_done  out  1  round result valid
- chk_pass  out  1  all NUM_RESULTS written and matched
- chk_correct_count  out  $clog2(NUM_RESULTS+1)  matched results
- chk_cycle_count  out  CYCLE_WIDTH  compute cycles of last round
- chk_stray_writes  out  8  out-of-range writes, saturating
- chk_round  out  ROUND_WIDTH  completed rounds
- chk_first_mismatch_address  out  ADDR_WIDTH  optional
- chk_first_mismatch_data  out  DATA_WIDTH  optional

Behaviour:
- Reset (reset_b=0 at posedge): all outputs and registers 0, FSM IDLE, match/written vectors cleared. Reset mid-round aborts; no round is counted.
- FSM:
  - IDLE→ARMED: dut_run=1 sampled. Clears vectors, correct, stray and cycle counters, and chk_done.
  - ARMED→BUSY: dut_busy=1.
  - BUSY→DRAIN: dut_busy=0.
  - DRAIN→DONE after 1 cycle; compare pipeline empty.
  - DONE→IDLE next cycle.
  - dut_run=1 in DONE or IDLE restarts a round.
- Cycle count: +1 every cycle in ARMED and BUSY, starting with the cycle dut_run is first sampled. Saturates at all-ones.
- Write in range: OUT_BASE ≤ addr < OUT_BASE+NUM_RESULTS, with write enable high, in any state other than IDLE.
  - idx = addr−OUT_BASE.
  - chk_golden_read_address = GOLDEN_BASE+idx, combinational from the write port in the same cycle. Otherwise it holds its last value.
  - Stage 1 registers idx and data.
  - Next cycle: match = (data==golden_chk_read_data). Set written[idx]; update match[idx].
  - correct_count +1 on a 0→1 transition of match[idx], −1 on 1→0. Last write wins.
- Back-to-back writes, including to the same index, are processed in order at full rate; no stall or backpressure.
- Out-of-range writes: chk_stray_writes +1, saturating at 255; no compare.
- In DONE: chk_done=1, chk_round +1 (wraps), chk_pass = (correct==NUM_RESULTS). chk_done stays 1 until the next round starts or reset.
- Writes in IDLE are ignored.

Optional Feature:
- CHK_MISMATCH_LOG_EN defined: on the first compare with match=0 in a round, capture the output address and the DUT data into chk_first_mismatch_*. Cleared at round start. Later mismatches do not overwrite.
- Not defined: both outputs constant 0; no capture registers.

Test Plan:
- Reset with reset_b=0 for 3 cycles while dut_run=1 → all outputs 0, FSM IDLE, chk_round=0.
- Round with 32 writes, all equal to golden, run→busy fall spanning 100 cycles → chk_done=1, chk_correct_count=32, chk_pass=1, chk_cycle_count=100, chk_round=1.
- Address 5 written wrong then rewritten correct on the next cycle → correct count 32, pass=1. With CHK_MISMATCH_LOG_EN: first_mismatch_address=5.
- Only 31 addresses written, all correct → chk_correct_count=31, chk_pass=0.
- 3 writes to address 12'h040 → chk_stray_writes=3; correct count unaffected.
- Two consecutive rounds, reset_b held 1 → second round clears counts at its dut_run; chk_round=2. Reset asserted during BUSY of round 3 → chk_round=0, chk_done=0.
